// File: rtl/key_turn_if.sv
// Handshake bundle between the game sequencer/buttons and the turn controller.
interface key_turn_if;
    logic       start;
    logic       halt;
    logic       key_l;
    logic       key_r;
    logic       LK;
    logic       RK;
    logic [1:0] turn;
    logic       foul;
    logic       timeout;

    modport master (
        output start, halt, key_l, key_r,
        input  LK, RK, turn, foul, timeout
    );

    modport slave (
        input  start, halt, key_l, key_r,
        output LK, RK, turn, foul, timeout
    );
endinterface

// File: rtl/key_turn_ctrl.sv
// Button conditioning and turn arbitration feeding the per-position light FSMs.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no game running, turn = 00, presses ignored
// S_LEFT  | left (red) player holds the turn, turn = 10
// S_RIGHT | right (green) player holds the turn, turn = 01
module key_turn_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int LOCKOUT = 4
) (
    input logic       clock,
    input logic       reset,
    key_turn_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LEFT  = 2'd1;
    localparam logic [1:0] S_RIGHT = 2'd2;

    localparam int TW = $clog2(TIMEOUT);
    localparam int LW = (LOCKOUT > 0) ? $clog2(LOCKOUT + 1) : 1;

    logic [1:0]    state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [LW-1:0] lock_cnt, lock_n;
    logic [1:0]    turn_n;
    logic          lk_n, rk_n, foul_n, to_n;

    logic sl1, sl2, sl3;
    logic sr1, sr2, sr3;
    logic press_l, press_r;
    logic locked, mine, other, expired;

    // s1/s2 resolve metastability, s3 holds the previous settled value for edge detect
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sl1 <= 1'b0;
            sl2 <= 1'b0;
            sl3 <= 1'b0;
            sr1 <= 1'b0;
            sr2 <= 1'b0;
            sr3 <= 1'b0;
        end else begin
            sl1 <= bus.key_l;
            sl2 <= sl1;
            sl3 <= sl2;
            sr1 <= bus.key_r;
            sr2 <= sr1;
            sr3 <= sr2;
        end
    end

    always_comb begin
        press_l = sl2 & ~sl3;
        press_r = sr2 & ~sr3;
        locked  = (lock_cnt != '0);
        mine    = (state == S_LEFT) ? press_l : press_r;
        other   = (state == S_LEFT) ? press_r : press_l;
        expired = (timer == TW'(TIMEOUT - 1));

        state_n = state;
        timer_n = timer;
        lock_n  = locked ? (lock_cnt - LW'(1)) : '0;
        lk_n    = 1'b0;
        rk_n    = 1'b0;
        foul_n  = 1'b0;
        to_n    = 1'b0;

        if (bus.halt) begin
            state_n = S_IDLE;
            timer_n = '0;
            lock_n  = '0;
        end else begin
            case (state)
                S_IDLE: begin
                    timer_n = '0;
                    if (bus.start) state_n = S_LEFT;
                end
                S_LEFT, S_RIGHT: begin
                    // accepted press outranks expiry, expiry outranks a foul
                    if (!locked && mine) begin
                        lk_n    = (state == S_LEFT);
                        rk_n    = (state == S_RIGHT);
                        state_n = (state == S_LEFT) ? S_RIGHT : S_LEFT;
                        timer_n = '0;
                        lock_n  = LW'(LOCKOUT);
                    end else if (expired) begin
                        to_n    = 1'b1;
                        state_n = (state == S_LEFT) ? S_RIGHT : S_LEFT;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + TW'(1);
                        foul_n  = !locked && other;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    timer_n = '0;
                end
            endcase
        end

        case (state_n)
            S_LEFT:  turn_n = 2'b10;
            S_RIGHT: turn_n = 2'b01;
            default: turn_n = 2'b00;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            timer       <= '0;
            lock_cnt    <= '0;
            bus.turn    <= 2'b00;
            bus.LK      <= 1'b0;
            bus.RK      <= 1'b0;
            bus.foul    <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            lock_cnt    <= lock_n;
            bus.turn    <= turn_n;
            bus.LK      <= lk_n;
            bus.RK      <= rk_n;
            bus.foul    <= foul_n;
            bus.timeout <= to_n;
        end
    end
endmodule

// File: tb/tb_key_turn_ctrl.sv
// Directed plus randomized check of key_turn_ctrl against a rule-level reference model.
module tb_key_turn_ctrl;
    localparam int TO = 8;
    localparam int LO = 3;

    logic clock;
    logic reset;
    key_turn_if bus ();

    key_turn_ctrl #(.TIMEOUT(TO), .LOCKOUT(LO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int n_lk, n_rk, n_foul, n_to;

    // reference model: raw samples per edge, whose turn, age of the turn, lockout left
    bit         hl[3];
    bit         hr[3];
    logic [1:0] m_turn;
    int         m_age;
    int         m_lock;
    logic       e_lk, e_rk, e_foul, e_to;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hl[i] = 1'b0;
            hr[i] = 1'b0;
        end
        m_turn = 2'b00;
        m_age  = 0;
        m_lock = 0;
        e_lk   = 1'b0;
        e_rk   = 1'b0;
        e_foul = 1'b0;
        e_to   = 1'b0;
    endtask

    task automatic model_edge(input bit st, input bit h, input bit kl, input bit kr);
        bit pl, pr, is_left, locked, mine, other;
        // a press is a key seen high two edges ago that was low three edges ago
        pl = hl[1] && !hl[2];
        pr = hr[1] && !hr[2];
        hl[2] = hl[1]; hl[1] = hl[0]; hl[0] = kl;
        hr[2] = hr[1]; hr[1] = hr[0]; hr[0] = kr;
        e_lk = 1'b0; e_rk = 1'b0; e_foul = 1'b0; e_to = 1'b0;
        if (h) begin
            m_turn = 2'b00;
            m_age  = 0;
            m_lock = 0;
            return;
        end
        locked = (m_lock > 0);
        if (m_lock > 0) m_lock = m_lock - 1;
        if (m_turn == 2'b00) begin
            if (st) begin
                m_turn = 2'b10;
                m_age  = 0;
            end
            return;
        end
        is_left = (m_turn == 2'b10);
        mine    = is_left ? pl : pr;
        other   = is_left ? pr : pl;
        if (!locked && mine) begin
            e_lk   = is_left;
            e_rk   = !is_left;
            m_turn = is_left ? 2'b01 : 2'b10;
            m_age  = 0;
            m_lock = LO;
        end else if (m_age == TO - 1) begin
            e_to   = 1'b1;
            m_turn = is_left ? 2'b01 : 2'b10;
            m_age  = 0;
        end else begin
            e_foul = !locked && other;
            m_age  = m_age + 1;
        end
    endtask

    task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".LK"},      {1'b0, bus.LK},      {1'b0, e_lk});
        chk({tag, ".RK"},      {1'b0, bus.RK},      {1'b0, e_rk});
        chk({tag, ".turn"},    bus.turn,            m_turn);
        chk({tag, ".foul"},    {1'b0, bus.foul},    {1'b0, e_foul});
        chk({tag, ".timeout"}, {1'b0, bus.timeout}, {1'b0, e_to});
    endtask

    // called at a falling edge: drive, let one rising edge pass, compare at the next falling edge
    task automatic step(input bit st, input bit h, input bit kl, input bit kr);
        bus.start = st;
        bus.halt  = h;
        bus.key_l = kl;
        bus.key_r = kr;
        @(posedge clock);
        model_edge(st, h, kl, kr);
        @(negedge clock);
        check_outputs("step");
        n_lk   += int'(bus.LK);
        n_rk   += int'(bus.RK);
        n_foul += int'(bus.foul);
        n_to   += int'(bus.timeout);
    endtask

    task automatic clear_tally();
        n_lk = 0; n_rk = 0; n_foul = 0; n_to = 0;
    endtask

    task automatic async_reset();
        #2 reset = 1'b1;
        model_reset();
        #1 check_outputs("async_reset");
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        bit kl, kr;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.halt  = 1'b0;
        bus.key_l = 1'b0;
        bus.key_r = 1'b0;
        model_reset();
        clear_tally();
        @(negedge clock);
        @(negedge clock);
        check_outputs("reset");
        reset = 1'b0;

        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("start_turn", bus.turn, 2'b10);

        // held left key: one LK, turn handed to the right
        clear_tally();
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0);
        chk_int("held_single_lk", n_lk, 1);
        chk("held_turn", bus.turn, 2'b01);

        // right player stalls on the very next edge
        clear_tally();
        step(0, 0, 0, 0);
        chk_int("stall_timeout", n_to, 1);
        chk("stall_turn", bus.turn, 2'b10);

        // out-of-turn right press in LEFT
        clear_tally();
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_int("foul_count", n_foul, 1);
        chk("foul_turn", bus.turn, 2'b10);

        // accepted LK, then a right press inside the lockout window is dropped
        clear_tally();
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_int("lock_lk", n_lk, 1);
        chk_int("lock_dropped_rk", n_rk, 0);
        chk_int("lock_no_foul", n_foul, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk_int("after_lock_rk", n_rk, 1);
        chk("after_lock_turn", bus.turn, 2'b10);

        // left press lands exactly on the expiry edge: press wins
        clear_tally();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        chk_int("coincide_lk", n_lk, 1);
        chk_int("coincide_no_to", n_to, 0);
        chk("coincide_turn", bus.turn, 2'b01);

        // eight silent edges in RIGHT
        clear_tally();
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        chk_int("idle8_timeout", n_to, 1);
        chk("idle8_turn", bus.turn, 2'b10);

        // both keys on the same edge in LEFT
        clear_tally();
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 0, 0);
        chk_int("both_lk", n_lk, 1);
        chk_int("both_rk", n_rk, 0);
        chk_int("both_foul", n_foul, 0);
        chk("both_turn", bus.turn, 2'b01);

        // halt in RIGHT, then a start and a mid-game asynchronous reset
        step(0, 1, 0, 0);
        chk("halt_turn", bus.turn, 2'b00);
        async_reset();
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("post_reset_idle", bus.turn, 2'b00);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        async_reset();
        chk("midgame_reset_turn", bus.turn, 2'b00);

        // randomized play
        kl = 1'b0;
        kr = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) kl = ~kl;
            if ($urandom_range(0, 3) == 0) kr = ~kr;
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                step($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0, kl, kr);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
